// File: rtl/apb2axi_rd_rsp_collector_if.sv
// Bundle of the AXI3 R channel, read-data-FIFO push port and completion port
// seen by the read response collector.
interface apb2axi_rd_rsp_collector_if #(
  parameter int TAG_NUM    = 16,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 64
);
  localparam int TAG_W = (TAG_NUM <= 1) ? 1 : $clog2(TAG_NUM);
  localparam int RDF_W = TAG_W + AXI_DATA_W + 3;
  // completion layout: {is_write, tag, num_beats[7:0], resp[1:0], error, err_beat_idx[7:0]}
  localparam int CPL_W = 1 + TAG_W + 8 + 2 + 1 + 8;

  logic [AXI_ID_W-1:0]   rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  logic                  rdf_valid;
  logic                  rdf_ready;
  logic [RDF_W-1:0]      rdf_entry;
  logic                  cpl_valid;
  logic                  cpl_ready;
  logic [CPL_W-1:0]      cpl_entry;

  modport master (
    output rid, rdata, rresp, rlast, rvalid, rdf_ready, cpl_ready,
    input  rready, rdf_valid, rdf_entry, cpl_valid, cpl_entry
  );

  modport slave (
    input  rid, rdata, rresp, rlast, rvalid, rdf_ready, cpl_ready,
    output rready, rdf_valid, rdf_entry, cpl_valid, cpl_entry
  );
endinterface

// File: rtl/apb2axi_rd_rsp_collector.sv
// Collects AXI3 read beats: forwards each beat tagged to the read data FIFO and
// emits one registered read completion per burst with beat count and error summary.
module apb2axi_rd_rsp_collector #(
  parameter int TAG_NUM    = 16,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  apb2axi_rd_rsp_collector_if.slave     bus
);
  localparam int TAG_W = (TAG_NUM <= 1) ? 1 : $clog2(TAG_NUM);
  localparam int RDF_W = TAG_W + AXI_DATA_W + 3;
  localparam int CPL_W = 1 + TAG_W + 8 + 2 + 1 + 8;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;
  localparam logic [7:0] CNT_MAX     = 8'd255;

  function automatic logic is_err(input logic [1:0] r);
    return (r == RESP_SLVERR) || (r == RESP_DECERR);
  endfunction

  // Error priority DECERR > SLVERR > OKAY; EXOKAY counts as OKAY here.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    if ((a == RESP_DECERR) || (b == RESP_DECERR)) begin
      r = RESP_DECERR;
    end else if ((a == RESP_SLVERR) || (b == RESP_SLVERR)) begin
      r = RESP_SLVERR;
    end else begin
      r = RESP_OKAY;
    end
    return r;
  endfunction

  logic [7:0] beat_cnt_q [TAG_NUM];
  logic       err_seen_q [TAG_NUM];
  logic [7:0] err_idx_q  [TAG_NUM];
  logic [1:0] resp_acc_q [TAG_NUM];
  logic       all_exok_q [TAG_NUM];

  logic             cpl_valid_q;
  logic [CPL_W-1:0] cpl_entry_q;

  logic [AXI_ID_W-1:0] rid_s;
  logic [TAG_W-1:0]    tag_s;
  logic                rready_s;
  logic                beat_acc_s;
  logic                cpl_load_s;
  logic [7:0]          idx_s;
  logic [7:0]          beat_cnt_d;
  logic                cur_err_s;
  logic                err_seen_d;
  logic [7:0]          err_idx_d;
  logic [1:0]          resp_acc_d;
  logic                all_exok_d;
  logic [1:0]          cpl_resp_s;
  logic [CPL_W-1:0]    cpl_entry_d;

  assign rid_s = bus.rid;
  assign tag_s = rid_s[TAG_W-1:0];

  // Handshake and merge of the current beat into its tag's running state.
  always_comb begin
    rready_s   = bus.rdf_ready & (~cpl_valid_q | bus.cpl_ready) & ~rst;
    beat_acc_s = bus.rvalid & rready_s;
    cpl_load_s = beat_acc_s & bus.rlast;
    idx_s      = beat_cnt_q[tag_s];
    if (idx_s == CNT_MAX) begin
      beat_cnt_d = CNT_MAX;
    end else begin
      beat_cnt_d = idx_s + 8'd1;
    end
    cur_err_s  = is_err(bus.rresp);
    err_seen_d = err_seen_q[tag_s] | cur_err_s;
    if (err_seen_q[tag_s]) begin
      err_idx_d = err_idx_q[tag_s];
    end else if (cur_err_s) begin
      err_idx_d = idx_s;
    end else begin
      err_idx_d = 8'd0;
    end
    resp_acc_d = resp_max(resp_acc_q[tag_s], bus.rresp);
    all_exok_d = all_exok_q[tag_s] & (bus.rresp == RESP_EXOKAY);
    if (err_seen_d) begin
      cpl_resp_s = resp_acc_d;
    end else if (all_exok_d) begin
      cpl_resp_s = RESP_EXOKAY;
    end else begin
      cpl_resp_s = RESP_OKAY;
    end
    cpl_entry_d = {1'b0, tag_s, beat_cnt_d, cpl_resp_s, err_seen_d, err_idx_d};
  end

  assign bus.rready    = rready_s;
  assign bus.rdf_valid = beat_acc_s;
  assign bus.rdf_entry = RDF_W'({tag_s, bus.rdata, bus.rlast, bus.rresp});
  assign bus.cpl_valid = cpl_valid_q;
  assign bus.cpl_entry = cpl_entry_q;

  // Per-tag bookkeeping; a burst's state returns to idle on its last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        beat_cnt_q[i] <= 8'd0;
        err_seen_q[i] <= 1'b0;
        err_idx_q[i]  <= 8'd0;
        resp_acc_q[i] <= RESP_OKAY;
        all_exok_q[i] <= 1'b1;
      end
    end else if (beat_acc_s) begin
      if (bus.rlast) begin
        beat_cnt_q[tag_s] <= 8'd0;
        err_seen_q[tag_s] <= 1'b0;
        err_idx_q[tag_s]  <= 8'd0;
        resp_acc_q[tag_s] <= RESP_OKAY;
        all_exok_q[tag_s] <= 1'b1;
      end else begin
        beat_cnt_q[tag_s] <= beat_cnt_d;
        err_seen_q[tag_s] <= err_seen_d;
        err_idx_q[tag_s]  <= err_idx_d;
        resp_acc_q[tag_s] <= resp_acc_d;
        all_exok_q[tag_s] <= all_exok_d;
      end
    end else begin
      beat_cnt_q <= beat_cnt_q;
    end
  end

  // Completion register: a new load wins over a drain so back-to-back has no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpl_valid_q <= 1'b0;
      cpl_entry_q <= '0;
    end else if (cpl_load_s) begin
      cpl_valid_q <= 1'b1;
      cpl_entry_q <= cpl_entry_d;
    end else if (cpl_valid_q && bus.cpl_ready) begin
      cpl_valid_q <= 1'b0;
      cpl_entry_q <= cpl_entry_q;
    end else begin
      cpl_valid_q <= cpl_valid_q;
      cpl_entry_q <= cpl_entry_q;
    end
  end
endmodule
